// File: rtl/ball_motion_engine_if.sv
// Pixel/status bus between the frame timing logic and ball_motion_engine.
// The master drives sync, pause and pixel coordinates. The slave returns
// the pixel colour and the sweep status flags.
interface ball_motion_engine_if #(
   parameter int PW = 16
);
   logic          vsync_i;
   logic          pause_i;
   logic [PW-1:0] hpos_i;
   logic [PW-1:0] vpos_i;
   logic [15:0]   rgb_o;
   logic          hit_o;
   logic          bounce_o;
   logic          busy_o;
   logic          overrun_o;

   modport master (
      output vsync_i, pause_i, hpos_i, vpos_i,
      input  rgb_o, hit_o, bounce_o, busy_o, overrun_o
   );

   modport slave (
      input  vsync_i, pause_i, hpos_i, vpos_i,
      output rgb_o, hit_o, bounce_o, busy_o, overrun_o
   );
endinterface

// File: rtl/ball_motion_engine.sv
// Multi-ball motion and pixel generator. Each frame tick (entry into the
// active vsync level) starts a sweep that moves one ball per cycle, bouncing
// it off the field walls. In parallel a registered pixel path colours every
// coordinate covered by a ball, with the lowest ball index winning.
module ball_motion_engine #(
   parameter int          NUM_BALLS = 4,
   parameter int          PW        = 16,
   parameter int          VW        = 8,
   parameter int          SIZE      = 4,
   parameter int          X_MIN     = 0,
   parameter int          X_MAX     = 639,
   parameter int          Y_MIN     = 0,
   parameter int          Y_MAX     = 479,
   parameter int          X_INIT    = 128,
   parameter int          Y_INIT    = 128,
   parameter int          SPACING   = 32,
   parameter int          VX_INIT   = -2,
   parameter int          VY_INIT   = 2,
   parameter bit          VSYNC_ACT = 1'b0,
   parameter logic [15:0] BG_COLOR  = 16'h0000
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   ball_motion_engine_if.slave  bus
);

   localparam int IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BALLS - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;

   // Field limits for the top-left corner of a sprite, one bit wider than a
   // position so that a step past either wall is still visible as a sign.
   localparam logic signed [PW:0] X_LO = (PW+1)'(X_MIN);
   localparam logic signed [PW:0] X_HI = (PW+1)'(X_MAX - SIZE + 1);
   localparam logic signed [PW:0] Y_LO = (PW+1)'(Y_MIN);
   localparam logic signed [PW:0] Y_HI = (PW+1)'(Y_MAX - SIZE + 1);

   typedef struct packed {
      logic [PW-1:0] pos;
      logic [VW-1:0] vel;
      logic          bnc;
   } axis_t;

   // Negate a velocity; the most negative value has no positive twin, so it
   // saturates to the largest positive value instead of wrapping to itself.
   function automatic logic [VW-1:0] neg_sat(input logic [VW-1:0] v);
      if (v == {1'b1, {(VW-1){1'b0}}}) return {1'b0, {(VW-1){1'b1}}};
      return -v;
   endfunction

   // One axis of the motion step: advance, then clamp and reflect on a wall.
   function automatic axis_t step_axis(input logic [PW-1:0]     pos,
                                       input logic [VW-1:0]     vel,
                                       input logic signed [PW:0] lo,
                                       input logic signed [PW:0] hi);
      logic signed [PW:0] n;
      axis_t              r;
      n     = $signed({1'b0, pos}) + $signed({{(PW+1-VW){vel[VW-1]}}, vel});
      r.pos = n[PW-1:0];
      r.vel = vel;
      r.bnc = 1'b0;
      if (n < lo) begin
         r.pos = lo[PW-1:0];
         r.vel = neg_sat(vel);
         r.bnc = 1'b1;
      end else if (n > hi) begin
         r.pos = hi[PW-1:0];
         r.vel = neg_sat(vel);
         r.bnc = 1'b1;
      end
      return r;
   endfunction

   // Coordinates left of / above the sprite wrap to large unsigned values.
   function automatic logic covers(input logic [PW-1:0] c, input logic [PW-1:0] p);
      logic [PW-1:0] d;
      d = c - p;
      return d < PW'(SIZE);
   endfunction

   function automatic logic [15:0] palette(input int k);
      case (k % 7)
         0:       return 16'hFFFF;
         1:       return 16'hF800;
         2:       return 16'h07E0;
         3:       return 16'h001F;
         4:       return 16'hFFE0;
         5:       return 16'hF81F;
         default: return 16'h07FF;
      endcase
   endfunction

   logic            r_vs_q;
   logic            r_vs_prev;
   logic            w_tick;
   logic [0:0]      r_state;
   logic [IW-1:0]   r_idx;
   logic            r_overrun;
   logic            r_bounce;
   logic [PW-1:0]   r_x  [NUM_BALLS];
   logic [PW-1:0]   r_y  [NUM_BALLS];
   logic [VW-1:0]   r_vx [NUM_BALLS];
   logic [VW-1:0]   r_vy [NUM_BALLS];
   axis_t           w_ax;
   axis_t           w_ay;
   logic [15:0]     w_rgb;
   logic            w_hit;
   logic [15:0]     r_rgb;
   logic            r_hit;

   // Register vsync once and keep the previous sample for edge detection.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, independent of order.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_vs_q    <= ~VSYNC_ACT;
         r_vs_prev <= ~VSYNC_ACT;
      end else begin
         r_vs_q    <= bus.vsync_i;
         r_vs_prev <= r_vs_q;
      end
   end

   assign w_tick = (r_vs_q == VSYNC_ACT) && (r_vs_prev != VSYNC_ACT);

   // Sweep controller: one ball per cycle; ticks while sweeping are dropped
   // and remembered in the sticky overrun flag.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_tick && r_state == ST_SWEEP) r_overrun <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_tick && !bus.pause_i) begin
                  r_state <= ST_SWEEP;
                  r_idx   <= '0;
               end
            end
            default: begin
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_IDLE;
                  r_idx   <= '0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
         endcase
      end
   end

   // Motion step for the ball currently addressed by the sweep.
   // NOTE: every always_comb output is assigned before any branch, so no
   // path leaves a value held and no latch is inferred.
   always_comb begin
      w_ax = step_axis(r_x[r_idx], r_vx[r_idx], X_LO, X_HI);
      w_ay = step_axis(r_y[r_idx], r_vy[r_idx], Y_LO, Y_HI);
   end

   // Ball state: write back the stepped ball during the sweep.
   // NOTE: the ball arrays are individual flops, not a RAM, so they take the
   // asynchronous reset like any other state and restart from init at once.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int k = 0; k < NUM_BALLS; k++) begin
            r_x[k]  <= PW'(X_INIT + k * SPACING);
            r_y[k]  <= PW'(Y_INIT + k * SPACING);
            r_vx[k] <= (k % 2 == 0) ? VW'(VX_INIT) : VW'(-VX_INIT);
            r_vy[k] <= VW'(VY_INIT);
         end
         r_bounce <= 1'b0;
      end else begin
         if (r_state == ST_SWEEP) begin
            r_x[r_idx]  <= w_ax.pos;
            r_y[r_idx]  <= w_ay.pos;
            r_vx[r_idx] <= w_ax.vel;
            r_vy[r_idx] <= w_ay.vel;
         end
         r_bounce <= (r_state == ST_SWEEP) && (w_ax.bnc || w_ay.bnc);
      end
   end

   // Pixel cover: scan from the highest index down so the lowest index wins.
   always_comb begin
      w_rgb = BG_COLOR;
      w_hit = 1'b0;
      for (int k = NUM_BALLS - 1; k >= 0; k--) begin
         if (covers(bus.hpos_i, r_x[k]) && covers(bus.vpos_i, r_y[k])) begin
            w_rgb = palette(k);
            w_hit = 1'b1;
         end
      end
   end

   // Output pixel register: one cycle of latency from the coordinates.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_rgb <= BG_COLOR;
         r_hit <= 1'b0;
      end else begin
         r_rgb <= w_rgb;
         r_hit <= w_hit;
      end
   end

   assign bus.rgb_o     = r_rgb;
   assign bus.hit_o     = r_hit;
   assign bus.bounce_o  = r_bounce;
   assign bus.busy_o    = (r_state == ST_SWEEP);
   assign bus.overrun_o = r_overrun;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Bench for ball_motion_engine: four instances with different field setups,
// a small frame-level reference model and a pixel scoreboard.
module tb_ball_motion_engine;

   localparam int ND   = 4;
   localparam int SIZE = 4;
   localparam int NB  [ND] = '{4,   1,   1,   8};
   localparam int XI  [ND] = '{128, 1,   636, 128};
   localparam int YI  [ND] = '{128, 128, 476, 128};
   localparam int SP  [ND] = '{32,  32,  32,  2};
   localparam int VXI [ND] = '{-2,  -2,  2,   -2};
   localparam int VYI [ND] = '{2,   2,   2,   2};
   localparam logic [15:0] PAL [7] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F,
                                       16'hFFE0, 16'hF81F, 16'h07FF};

   logic          clk = 1'b0;
   logic          rst_n;
   logic [ND-1:0] vs;
   logic [ND-1:0] pause;
   logic [15:0]   hpos;
   logic [15:0]   vpos;
   logic [15:0]   rgb_a [ND];
   logic [ND-1:0] hit_a;
   logic [ND-1:0] bnc_a;
   logic [ND-1:0] busy_a;
   logic [ND-1:0] ovr_a;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      ball_motion_engine_if #(.PW(16)) bif ();
      assign bif.vsync_i = vs[g];
      assign bif.pause_i = pause[g];
      assign bif.hpos_i  = hpos;
      assign bif.vpos_i  = vpos;
      assign rgb_a[g]    = bif.rgb_o;
      assign hit_a[g]    = bif.hit_o;
      assign bnc_a[g]    = bif.bounce_o;
      assign busy_a[g]   = bif.busy_o;
      assign ovr_a[g]    = bif.overrun_o;

      ball_motion_engine #(
         .NUM_BALLS (NB[g]),
         .X_INIT    (XI[g]),
         .Y_INIT    (YI[g]),
         .SPACING   (SP[g]),
         .VX_INIT   (VXI[g]),
         .VY_INIT   (VYI[g])
      ) u_dut (
         .clk_i    (clk),
         .reset_ni (rst_n),
         .bus      (bif.slave)
      );
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: ball positions and velocities per instance.
   int mx [ND][8];
   int my [ND][8];
   int mvx[ND][8];
   int mvy[ND][8];

   function automatic void model_reset();
      for (int d = 0; d < ND; d++)
         for (int k = 0; k < NB[d]; k++) begin
            mx[d][k]  = XI[d] + k * SP[d];
            my[d][k]  = YI[d] + k * SP[d];
            mvx[d][k] = (k % 2 == 1) ? -VXI[d] : VXI[d];
            mvy[d][k] = VYI[d];
         end
   endfunction

   function automatic void axis(input int p_in, input int v_in, input int lo, input int hi,
                                output int p, output int v, output bit b);
      int n;
      n = p_in + v_in;
      p = n; v = v_in; b = 1'b0;
      if (n < lo)      begin p = lo; v = -v_in; b = 1'b1; end
      else if (n > hi) begin p = hi; v = -v_in; b = 1'b1; end
   endfunction

   // Advance every ball of instance d by one frame; returns bouncing balls.
   function automatic int model_frame(input int d);
      int  cnt, p, v;
      bit  bx, by;
      cnt = 0;
      for (int k = 0; k < NB[d]; k++) begin
         axis(mx[d][k], mvx[d][k], 0, 639 - SIZE + 1, p, v, bx);
         mx[d][k] = p; mvx[d][k] = v;
         axis(my[d][k], mvy[d][k], 0, 479 - SIZE + 1, p, v, by);
         my[d][k] = p; mvy[d][k] = v;
         if (bx || by) cnt++;
      end
      return cnt;
   endfunction

   typedef struct {
      int          d;
      string       tag;
      logic [15:0] rgb;
      logic        hit;
   } exp_t;

   exp_t sb[$];

   // Drive one coordinate, queue the expectation, compare one cycle later.
   task automatic probe_exp(input int d, input int x, input int y,
                            input logic [15:0] rgb, input logic hit, input string tag);
      exp_t e;
      hpos  = 16'(x);
      vpos  = 16'(y);
      e.d   = d;
      e.tag = tag;
      e.rgb = rgb;
      e.hit = hit;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      check({e.tag, "_rgb"}, 32'(rgb_a[e.d]), 32'(e.rgb));
      check({e.tag, "_hit"}, 32'(hit_a[e.d]), 32'(e.hit));
   endtask

   task automatic probe_m(input int d, input int x, input int y, input string tag);
      logic [15:0] rgb;
      logic        hit;
      rgb = 16'h0000;
      hit = 1'b0;
      for (int k = NB[d] - 1; k >= 0; k--)
         if (x >= mx[d][k] && x < mx[d][k] + SIZE && y >= my[d][k] && y < my[d][k] + SIZE) begin
            rgb = PAL[k % 7];
            hit = 1'b1;
         end
      probe_exp(d, x, y, rgb, hit, tag);
   endtask

   // One vsync pulse on instance d; counts busy cycles and bounce pulses.
   task automatic do_tick(input int d, input bit expect_upd, input string tag);
      int bc, bn, exp_b;
      bc    = 0;
      bn    = 0;
      exp_b = expect_upd ? model_frame(d) : 0;
      vs[d] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (busy_a[d]) bc++;
         if (bnc_a[d])  bn++;
      end
      vs[d] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_busy_cycles"}, bc, expect_upd ? NB[d] : 0);
      check({tag, "_bounces"}, bn, exp_b);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bc, seen, w;
      rst_n = 1'b0;
      vs    = '1;
      pause = '0;
      hpos  = '0;
      vpos  = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_rgb", 32'(rgb_a[0]), 32'h0000);
      check("rst_hit", 32'(hit_a), 32'h0);
      check("rst_busy", 32'(busy_a), 32'h0);
      check("rst_overrun", 32'(ovr_a), 32'h0);
      check("rst_bounce", 32'(bnc_a), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("no_tick_after_rst", 32'(busy_a), 32'h0);

      // Initial placement and priority
      probe_exp(0, 128, 128, 16'hFFFF, 1'b1, "init_b0");
      probe_exp(0, 160, 160, 16'hF800, 1'b1, "init_b1");
      probe_exp(0, 400, 400, 16'h0000, 1'b0, "empty");
      probe_exp(3, 130, 130, 16'hFFFF, 1'b1, "prio_01");
      probe_exp(3, 132, 132, 16'hF800, 1'b1, "prio_12");
      probe_exp(3, 141, 141, 16'hF81F, 1'b1, "prio_56");
      probe_exp(3, 145, 145, 16'hFFFF, 1'b1, "pal_wrap7");
      probe_exp(3, 127, 127, 16'h0000, 1'b0, "wrap_left");

      // Default frame update
      do_tick(0, 1'b1, "tick0");
      probe_exp(0, 126, 130, 16'hFFFF, 1'b1, "mv_b0");
      probe_exp(0, 125, 130, 16'h0000, 1'b0, "mv_b0_left");
      probe_exp(0, 162, 162, 16'hF800, 1'b1, "mv_b1");
      probe_exp(0, 161, 162, 16'h0000, 1'b0, "mv_b1_left");
      probe_m(0, 190, 194, "mv_b2");
      probe_m(0, 223, 227, "mv_b3_corner");

      // Left wall
      do_tick(1, 1'b1, "lwall");
      probe_exp(1, 0, 130, 16'hFFFF, 1'b1, "lwall_x0");
      probe_exp(1, 4, 130, 16'h0000, 1'b0, "lwall_x4");
      do_tick(1, 1'b1, "lwall2");
      probe_exp(1, 2, 132, 16'hFFFF, 1'b1, "lwall2_x2");
      probe_exp(1, 1, 132, 16'h0000, 1'b0, "lwall2_x1");

      // Corner: both axes bounce, one pulse
      do_tick(2, 1'b1, "corner");
      probe_exp(2, 636, 476, 16'hFFFF, 1'b1, "corner_tl");
      probe_exp(2, 639, 479, 16'hFFFF, 1'b1, "corner_br");
      probe_exp(2, 635, 476, 16'h0000, 1'b0, "corner_out");
      do_tick(2, 1'b1, "corner2");
      probe_exp(2, 634, 474, 16'hFFFF, 1'b1, "corner2_tl");
      probe_exp(2, 638, 478, 16'h0000, 1'b0, "corner2_out");

      // Paused tick leaves everything in place
      pause[0] = 1'b1;
      do_tick(0, 1'b0, "pause");
      pause[0] = 1'b0;
      probe_exp(0, 126, 130, 16'hFFFF, 1'b1, "pause_hold");

      // Second tick during a sweep: flagged and dropped
      check("ovr_pre", 32'(ovr_a[3]), 32'h0);
      void'(model_frame(3));
      bc    = 0;
      seen  = -1;
      vs[3] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (busy_a[3]) bc++;
         if (busy_a[3] && seen < 0) begin
            seen  = i;
            vs[3] = 1'b1;
         end else if (seen >= 0 && i == seen + 1) begin
            vs[3] = 1'b0;
         end
      end
      vs[3] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("ovr_busy_cycles", bc, 8);
      check("ovr_flag", 32'(ovr_a[3]), 32'h1);
      probe_exp(3, 126, 130, 16'hFFFF, 1'b1, "ovr_b0_once");
      probe_m(3, 132, 132, "ovr_b1_once");

      // Asynchronous reset in the middle of a sweep
      vs[0] = 1'b0;
      w = 0;
      while (!busy_a[0] && w < 10) begin
         @(posedge clk); #1;
         w++;
      end
      check("midrst_busy_seen", 32'(busy_a[0]), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy_async", 32'(busy_a[0]), 32'h0);
      check("midrst_ovr_async", 32'(ovr_a[3]), 32'h0);
      vs = '1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      probe_exp(0, 128, 128, 16'hFFFF, 1'b1, "post_rst_b0");
      probe_exp(0, 126, 130, 16'h0000, 1'b0, "post_rst_old");
      probe_exp(3, 142, 142, 16'h07FF, 1'b1, "post_rst_b6");
      probe_exp(1, 1, 128, 16'hFFFF, 1'b1, "post_rst_d1");
      do_tick(0, 1'b1, "post_rst_tick");
      probe_exp(0, 126, 130, 16'hFFFF, 1'b1, "post_rst_mv");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
